// File: rtl/ALU_def.sv
// Shared definitions for the sequential ALU: operation codes and the
// iteration modes used by the multi-cycle shift/multiply unit.
package ALU_def;

    localparam int ALU_CTRL_W = 4;

    // Operation select. Codes 13..15 are undefined and produce a zero result.
    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDC = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_NEG  = 4'd5,
        ALU_LTS  = 4'd6,
        ALU_LT   = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_SUBB = 4'd11,
        ALU_MUL  = 4'd12
    } ALU_CTRL;

    // Per-iteration behaviour of the iterative unit once the shift direction
    // implied by the sign of b has been resolved.
    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_SRA = 2'd2,
        IT_MUL = 2'd3
    } iter_mode_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative engine: one shift step or one shift-add multiply step per cycle.
// done is high in the cycle of the final step; res_lo/res_hi carry the value
// that step produces so the caller can register it on the same edge.
module alu_iter_unit
    import ALU_def::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  ALU_CTRL          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH + 1);
    // WIDTH as a bit vector, zero-extended so any WIDTH can be sliced safely.
    localparam logic [WIDTH+31:0] LP_W_WIDE  = {{WIDTH{1'b0}}, WIDTH};
    localparam logic [WIDTH-1:0]  LP_W_OPW   = LP_W_WIDE[WIDTH-1:0];
    localparam logic [CW-1:0]     LP_W_CNT   = LP_W_WIDE[CW-1:0];
    localparam logic [CW-1:0]     LP_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     LP_CNT_0   = {CW{1'b0}};

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_mcand;
    iter_mode_t       r_mode;

    logic [WIDTH-1:0] w_mag;
    logic [CW-1:0]    w_k;
    logic [CW-1:0]    w_cnt_init;
    iter_mode_t       w_mode;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_hi_nxt;

    // Shift magnitude from signed b; counts of WIDTH or more saturate to WIDTH.
    assign w_mag      = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
    assign w_k        = (w_mag >= LP_W_OPW) ? LP_W_CNT : w_mag[CW-1:0];
    assign w_cnt_init = (w_mode == IT_MUL) ? LP_W_CNT : w_k;

    // Resolve the step direction: a negative amount reverses the shift.
    always_comb begin
        w_mode = IT_SHL;
        case (op)
            ALU_SLL: w_mode = b[WIDTH-1] ? IT_SHR : IT_SHL;
            ALU_SRL: w_mode = b[WIDTH-1] ? IT_SHL : IT_SHR;
            ALU_SRA: w_mode = b[WIDTH-1] ? IT_SHL : IT_SRA;
            ALU_MUL: w_mode = IT_MUL;
            default: w_mode = IT_SHL;
        endcase
    end

    // One iteration: shift r_lo, or add the multiplicand into the high half
    // and shift the {hi,lo} product/multiplier pair right by one.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_lo_nxt = r_lo;
        w_hi_nxt = r_hi;
        case (r_mode)
            IT_SHL: w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            IT_SHR: w_lo_nxt = {1'b0, r_lo[WIDTH-1:1]};
            IT_SRA: w_lo_nxt = {r_lo[WIDTH-1], r_lo[WIDTH-1:1]};
            IT_MUL: begin
                w_hi_nxt = w_sum[WIDTH:1];
                w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
            end
            default: w_lo_nxt = r_lo;
        endcase
    end

    // Load operands on start, then step and count down until the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= LP_CNT_0;
            r_lo    <= {WIDTH{1'b0}};
            r_hi    <= {WIDTH{1'b0}};
            r_mcand <= {WIDTH{1'b0}};
            r_mode  <= IT_SHL;
        end else if (start) begin
            r_busy  <= (w_cnt_init != LP_CNT_0);
            r_cnt   <= w_cnt_init;
            r_lo    <= (w_mode == IT_MUL) ? b : a;
            r_hi    <= {WIDTH{1'b0}};
            r_mcand <= a;
            r_mode  <= w_mode;
        end else if (r_busy) begin
            r_lo   <= w_lo_nxt;
            r_hi   <= w_hi_nxt;
            r_cnt  <= r_cnt - LP_CNT_ONE;
            r_busy <= (r_cnt != LP_CNT_ONE);
        end else begin
            r_busy <= 1'b0;
        end
    end

    assign busy   = r_busy;
    assign done   = r_busy && (r_cnt == LP_CNT_ONE);
    assign res_lo = w_lo_nxt;
    assign res_hi = w_hi_nxt;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-generic ALU with a persistent carry flag. Single-cycle ops
// complete on the accept edge; shifts and MUL run in alu_iter_unit.
module alu_seq
    import ALU_def::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  ALU_CTRL          ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LP_ZERO = {WIDTH{1'b0}};

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_out_hi;
    logic             r_zero;
    logic             r_carry;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_single;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_c;
    logic             w_it_busy;
    logic             w_it_done;
    logic [WIDTH-1:0] w_it_lo;
    logic [WIDTH-1:0] w_it_hi;

    // Accept in IDLE, or in DONE when the current result is retired this edge.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready = 1'b1;
            ST_DONE: w_in_ready = out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid && w_in_ready;

    // Single-cycle datapath; w_sc_c defaults to the held carry so only the
    // add/subtract family changes it. Non-zero shifts and MUL go iterative.
    always_comb begin
        w_sum    = {(WIDTH+1){1'b0}};
        w_sc_res = LP_ZERO;
        w_sc_c   = r_carry;
        w_single = 1'b1;
        case (ctrl)
            ALU_ADD: begin
                w_sum    = {1'b0, a} + {1'b0, b};
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_c   = w_sum[WIDTH];
            end
            ALU_ADDC: begin
                w_sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_carry};
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_c   = w_sum[WIDTH];
            end
            ALU_SUB: begin
                w_sum    = {1'b0, a} - {1'b0, b};
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_c   = w_sum[WIDTH];
            end
            ALU_SUBB: begin
                w_sum    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, r_carry};
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_c   = w_sum[WIDTH];
            end
            ALU_AND: w_sc_res = a & b;
            ALU_OR:  w_sc_res = a | b;
            ALU_NEG: w_sc_res = ~a;
            ALU_LTS: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_LT:  w_sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                if (b == LP_ZERO) begin
                    w_sc_res = a;
                end else begin
                    w_single = 1'b0;
                end
            end
            ALU_MUL: w_single = 1'b0;
            default: w_sc_res = LP_ZERO;
        endcase
    end

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_accept && !w_single),
        .op     (ctrl),
        .a      (a),
        .b      (b),
        .busy   (w_it_busy),
        .done   (w_it_done),
        .res_lo (w_it_lo),
        .res_hi (w_it_hi)
    );

    // Handshake FSM with registered result, zero and carry flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out       <= LP_ZERO;
            r_out_hi    <= LP_ZERO;
            r_zero      <= 1'b1;
            r_carry     <= 1'b0;
        end else if (w_accept) begin
            if (w_single) begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
                r_out       <= w_sc_res;
                r_out_hi    <= LP_ZERO;
                r_zero      <= (w_sc_res == LP_ZERO);
                r_carry     <= w_sc_c;
            end else begin
                r_state     <= ST_BUSY;
                r_out_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_IDLE;
                ST_BUSY: begin
                    if (w_it_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out       <= w_it_lo;
                        r_out_hi    <= w_it_hi;
                        r_zero      <= (w_it_lo == LP_ZERO);
                    end else if (!w_it_busy) begin
                        // Iterative unit idle without finishing: recover.
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_hi    = r_out_hi;
    assign zero      = r_zero;
    assign carry     = r_carry;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, hand
// sequences for stall/back-to-back/reset, and random ops against a model.
module tb_alu_seq;
    import ALU_def::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    ALU_CTRL    ctrl;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [7:0] out_hi;
    logic       zero;
    logic       carry;

    int n_checks = 0;
    int n_errors = 0;
    logic m_carry;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .zero      (zero),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        ALU_CTRL    c;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] e_lo;
        logic [7:0] e_hi;
        logic       e_z;
        logic       e_c;
        int         e_lat;
    } vec_t;

    vec_t tv[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour from the operation rules, using plain integer maths.
    function automatic void model(input ALU_CTRL c, input logic [7:0] ia, input logic [7:0] ib,
                                  input logic cin, output logic [7:0] lo, output logic [7:0] hi,
                                  output logic cout, output int lat);
        int s;
        int m;
        logic [15:0] p;
        lo = 8'h00; hi = 8'h00; cout = cin; lat = 1;
        case (c)
            ALU_ADD:  begin s = int'(ia) + int'(ib); lo = s[7:0]; cout = (s > 255); end
            ALU_ADDC: begin s = int'(ia) + int'(ib) + int'(cin); lo = s[7:0]; cout = (s > 255); end
            ALU_SUB:  begin s = int'(ia) - int'(ib); lo = s[7:0]; cout = (ia < ib); end
            ALU_SUBB: begin s = int'(ia) - int'(ib) - int'(cin); lo = s[7:0]; cout = (s < 0); end
            ALU_AND:  lo = ia & ib;
            ALU_OR:   lo = ia | ib;
            ALU_NEG:  lo = ~ia;
            ALU_LTS:  lo = ($signed(ia) < $signed(ib)) ? 8'd1 : 8'd0;
            ALU_LT:   lo = (ia < ib) ? 8'd1 : 8'd0;
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                s = int'($signed(ib));
                m = (s < 0) ? -s : s;
                lat = 1 + ((m < 8) ? m : 8);
                if (c == ALU_SRA && s >= 0) lo = $signed(ia) >>> m;
                else if ((c == ALU_SLL && s >= 0) || (c != ALU_SLL && s < 0)) lo = ia << m;
                else lo = ia >> m;
            end
            ALU_MUL: begin
                p = {8'h00, ia} * {8'h00, ib};
                lo = p[7:0]; hi = p[15:8]; lat = 9;
            end
            default: lo = 8'h00;
        endcase
    endfunction

    // Offer one op from IDLE; keep in_valid high with junk inputs until out_valid.
    task automatic run_op(input ALU_CTRL c, input logic [7:0] va, input logic [7:0] vb, output int lat);
        @(negedge clk);
        ctrl = c; a = va; b = vb; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        lat = 1;
        ctrl = ALU_CTRL'(4'($urandom_range(15, 0))); a = 8'($urandom); b = 8'($urandom);
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            ctrl = ALU_CTRL'(4'($urandom_range(15, 0))); a = 8'($urandom); b = 8'($urandom);
        end
        if (lat >= 40) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic consume();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
    endtask

    task automatic run_model_op(input ALU_CTRL c, input logic [7:0] va, input logic [7:0] vb);
        logic [7:0] e_lo, e_hi;
        logic e_c;
        int e_lat, lat;
        model(c, va, vb, m_carry, e_lo, e_hi, e_c, e_lat);
        run_op(c, va, vb, lat);
        chk("rnd_out", out, e_lo);
        chk("rnd_hi", out_hi, e_hi);
        chk("rnd_zero", zero, (e_lo == 8'h00));
        chk("rnd_carry", carry, e_c);
        chk("rnd_lat", lat, e_lat);
        m_carry = e_c;
        repeat ($urandom_range(2, 0)) begin
            @(posedge clk); #1;
            chk("rnd_stable", out, e_lo);
        end
        consume();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] e_lo, e_hi, hold_lo;
        logic e_c;
        int e_lat;
        ALU_CTRL    bb_c[4];
        logic [7:0] bb_a[4];
        logic [7:0] bb_b[4];

        tv[0]  = '{"add_ff_01",  ALU_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1};
        tv[1]  = '{"addc_0_0",   ALU_ADDC, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1};
        tv[2]  = '{"sub_5_7",    ALU_SUB,  8'h05, 8'h07, 8'hFE, 8'h00, 1'b0, 1'b1, 1};
        tv[3]  = '{"subb_10_0",  ALU_SUBB, 8'h10, 8'h00, 8'h0F, 8'h00, 1'b0, 1'b0, 1};
        tv[4]  = '{"and",        ALU_AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1};
        tv[5]  = '{"or",         ALU_OR,   8'h0F, 8'h30, 8'h3F, 8'h00, 1'b0, 1'b0, 1};
        tv[6]  = '{"neg",        ALU_NEG,  8'h5A, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0, 1};
        tv[7]  = '{"lts",        ALU_LTS,  8'h80, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1};
        tv[8]  = '{"lt",         ALU_LT,   8'h80, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1};
        tv[9]  = '{"sra_90_2",   ALU_SRA,  8'h90, 8'h02, 8'hE4, 8'h00, 1'b0, 1'b0, 3};
        tv[10] = '{"sll_81_m2",  ALU_SLL,  8'h81, 8'hFE, 8'h20, 8'h00, 1'b0, 1'b0, 3};
        tv[11] = '{"srl_ff_9",   ALU_SRL,  8'hFF, 8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 9};
        tv[12] = '{"mul_ff_ff",  ALU_MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 9};
        tv[13] = '{"sll_zero",   ALU_SLL,  8'h33, 8'h00, 8'h33, 8'h00, 1'b0, 1'b0, 1};
        tv[14] = '{"sra_minneg", ALU_SRA,  8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 9};
        tv[15] = '{"undef_13",   ALU_CTRL'(4'd13), 8'hAA, 8'h55, 8'h00, 8'h00, 1'b1, 1'b0, 1};
        tv[16] = '{"sub_0_1",    ALU_SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
        tv[17] = '{"undef_15",   ALU_CTRL'(4'd15), 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b1, 1};
        tv[18] = '{"sra_sat",    ALU_SRA,  8'h80, 8'h7F, 8'hFF, 8'h00, 1'b0, 1'b1, 9};
        tv[19] = '{"addc_1_1",   ALU_ADDC, 8'h01, 8'h01, 8'h03, 8'h00, 1'b0, 1'b0, 1};
        tv[20] = '{"srl_m1",     ALU_SRL,  8'h80, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 2};
        tv[21] = '{"mul_d_b",    ALU_MUL,  8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 9};

        bb_c = '{ALU_ADD, ALU_ADDC, ALU_ADD, ALU_SUBB};
        bb_a = '{8'hFF, 8'h10, 8'h80, 8'h05};
        bb_b = '{8'h02, 8'h20, 8'h80, 8'h01};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ctrl = ALU_ADD; a = 8'h00; b = 8'h00;
        m_carry = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 8'h00);
        chk("rst_out_hi", out_hi, 8'h00);
        chk("rst_zero", zero, 1);
        chk("rst_carry", carry, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table, applied in order (carry chains between rows).
        for (int i = 0; i < 22; i++) begin
            run_op(tv[i].c, tv[i].va, tv[i].vb, lat);
            chk({tv[i].nm, "_out"},   out,    tv[i].e_lo);
            chk({tv[i].nm, "_hi"},    out_hi, tv[i].e_hi);
            chk({tv[i].nm, "_zero"},  zero,   tv[i].e_z);
            chk({tv[i].nm, "_carry"}, carry,  tv[i].e_c);
            chk({tv[i].nm, "_lat"},   lat,    tv[i].e_lat);
            m_carry = tv[i].e_c;
            consume();
        end

        // Stall in DONE for 5 cycles with a new op offered: nothing moves.
        model(ALU_ADD, 8'h12, 8'h34, m_carry, hold_lo, e_hi, e_c, e_lat);
        run_op(ALU_ADD, 8'h12, 8'h34, lat);
        m_carry = e_c;
        repeat (5) begin
            @(negedge clk);
            ctrl = ALU_ADD; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_out", out, hold_lo);
            chk("hold_zero", zero, (hold_lo == 8'h00));
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end

        // Back-to-back single-cycle ops, one result per edge, carry forwarded.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ctrl = bb_c[i]; a = bb_a[i]; b = bb_b[i]; in_valid = 1'b1; out_ready = 1'b1;
            model(bb_c[i], bb_a[i], bb_b[i], m_carry, e_lo, e_hi, e_c, e_lat);
            m_carry = e_c;
            @(posedge clk); #1;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_out", out, e_lo);
            chk("b2b_zero", zero, (e_lo == 8'h00));
            chk("b2b_carry", carry, e_c);
        end
        consume();

        // Reset in the middle of a MUL: asynchronous clear, no stale result.
        run_model_op(ALU_SUB, 8'h00, 8'h01);
        @(negedge clk);
        ctrl = ALU_MUL; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out", out, 8'h00);
        chk("arst_out_hi", out_hi, 8'h00);
        chk("arst_zero", zero, 1);
        chk("arst_carry", carry, 0);
        m_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            chk("arst_no_stale", out_valid, 0);
        end

        // Random operations against the model.
        for (int i = 0; i < 120; i++) begin
            logic [7:0] ra, rb;
            ALU_CTRL rc;
            rc = ALU_CTRL'(4'($urandom_range(15, 0)));
            ra = 8'($urandom);
            if ($urandom_range(1, 0) == 0) rb = 8'($urandom);
            else rb = 8'($urandom_range(20, 0)) - 8'd10;
            run_model_op(rc, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
